multicycle_control_fsm: RTL

//   Control FSM for the multicycle datapath. Decodes the IR opcode and drives every datapath

---
 rtl/multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control FSM for the multicycle datapath. It sequences fetch, decode,
//   execute, memory and writeback one state per cycle, and drives every
//   datapath control line from the current state together with the opcode,
//   the ALU zero flag and the memory-ready handshake. It stalls in FETCH,
//   MEMRD and MEMWR until mem_ready is high, counts retired instructions,
//   and parks in HALT until reset.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; all outputs are forced to 0 while low
//   opcode       IR[31:26], valid from DECODE onward
//   alu_zero     ALU zero flag for the current cycle
//   mem_ready    memory access completes this cycle
//   PCWrite .. RegDst   single-bit datapath controls
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   ALUSrcB      00 regB, 01 const 1, 10 sign-ext imm, 11 zero-ext imm
//   ALUOp        ALU function (0000 ADD, 0001 SUB)
//   halted       high while in HALT
//   illegal_op   one-cycle pulse when DECODE sees an illegal opcode
//   instr_count  retired instruction count, wraps at 2^CNT_W
module multicycle_control_fsm #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WBALU,
        S_MEMADDR,
        S_MEMRD,
        S_WBMEM,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // Opcode class decode
    logic [5:0] op;
    logic       is_ralu, is_isext, is_izext, is_alu;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_illegal;

    assign op         = opcode[5:0];
    assign is_ralu    = (op[5:4] == 2'b00);
    assign is_isext   = (op[5:4] == 2'b01);
    assign is_izext   = (op[5:4] == 2'b10);
    assign is_alu     = is_ralu | is_isext | is_izext;
    assign is_lw      = (op == 6'b110000);
    assign is_sw      = (op == 6'b110001);
    assign is_beq     = (op == 6'b110010);
    assign is_bne     = (op == 6'b110011);
    assign is_j       = (op == 6'b110100);
    assign is_halt    = (op == 6'b111111);
    assign is_illegal = ~(is_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_halt);

    // Next state and retire detection
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_alu)              state_d = S_EXEC;
                else if (is_lw || is_sw) state_d = S_MEMADDR;
                else if (is_beq || is_bne) state_d = S_BRANCH;
                else if (is_j)           state_d = S_JUMP;
                else if (is_halt)        state_d = S_HALT;
                else                     state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_WBALU;
            S_WBALU: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMADDR: state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_WBMEM;
            S_WBMEM: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
        count_d = count_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Control outputs: decoded from state plus live inputs, and gated by
    // reset so they drop the instant reset goes low without waiting for a clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b10;
                    illegal_op = is_illegal;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = is_ralu ? 2'b00 : (is_isext ? 2'b10 : 2'b11);
                    ALUOp   = ALUOP_W'(op[3:0]);
                end
                S_WBALU:   RegWrite = 1'b1;
                S_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_WBMEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b00;
                    ALUOp       = ALU_SUB;
                    PCSource    = 2'b01;
                    PCWriteCond = is_beq ? alu_zero : ~alu_zero;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr_count = count_q;

endmodule
